line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
- Frame-level sequencer for a chain of KSIZE-1 dynamic line buffers feeding a KSIZE x KSIZE sliding-window stage.
- Latches frame geometry at start-of-frame and tracks the column/row position of every accepted pixel.
- Drives the line-buffer write enable and width.
- Emits window-valid, coordinate and end-of-line/frame strobes, aligned to the 1-cycle line-buffer read latency.

Parameters:
- KSIZE, 3, window size (odd, >=3); the number of line buffers is KSIZE-1.
- MAX_WIDTH, 2048, largest legal frame width; must equal the line-buffer depth.
- MAX_HEIGHT, 2048, largest legal frame height.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_cfg_width  in  16  frame width in pixels; sampled only on an accepted SOF
- i_cfg_height  in  16  frame height in lines; sampled only on an accepted SOF
- i_sof  in  1  start-of-frame; qualifies the pixel presented on the same cycle
- i_valid  in  1  pixel strobe
- o_lb_we  out  1  line-buffer write enable (combinational)
- o_lb_width  out  16  latched width driven to the line buffers
- o_win_valid  out  1  full KSIZE x KSIZE window available
- o_col  out  16  column of the pixel this output cycle refers to
- o_row  out  16  row of the pixel this output cycle refers to
- o_eol  out  1  last pixel of a line
- o_eof  out  1  last pixel of the frame
- o_busy  out  1  frame in progress
- o_cfg_err  out  1  one-cycle pulse: SOF rejected

Behaviour:
- Reset: state=IDLE; counters, latched width/height and all registered outputs = 0; o_lb_we=0.
- States:
  - IDLE: waiting for a legal SOF.
  - FILL: row < KSIZE-1; line buffers priming.
  - RUN: row >= KSIZE-1.
- Accepted pixel: i_valid=1 in FILL or RUN, or i_valid=1 & i_sof=1 with legal config in any state.
- o_lb_we = 1 exactly on accepted-pixel cycles, combinational, same cycle as the data.
- SOF legality: KSIZE <= width <= MAX_WIDTH and KSIZE <= height <= MAX_HEIGHT.
- Legal SOF (requires i_valid=1):
  - Latch width/height.
  - The SOF pixel is (row 0, col 0).
  - Next col=1, row=0; state -> FILL.
- Illegal SOF: pulse o_cfg_err next cycle; pixel not accepted; state -> IDLE (aborts any frame in progress).
- i_sof without i_valid: ignored.
- SOF in FILL/RUN: aborts the current frame with no o_eof and restarts from (0,0) as above. Line-buffer contents are not cleared; window gating hides stale data.
- i_valid in IDLE without SOF: dropped; o_lb_we=0.
- Counters:
  - col increments per accepted pixel.
  - At col=width-1, col wraps to 0 and row increments.
  - FILL -> RUN on the wrap out of row KSIZE-2.
  - At (height-1, width-1), state -> IDLE and counters clear.
  - Arithmetic is 16-bit unsigned; compares use the latched width/height, never the live i_cfg inputs.
- Output timing: all window outputs are registered, 1 cycle after the accepted pixel, matching the line-buffer read latency.
  - o_col/o_row = coordinates of that pixel.
  - o_win_valid = 1 iff row >= KSIZE-1 and col >= KSIZE-1.
  - o_eol = 1 iff col = width-1.
  - o_eof = 1 iff row = height-1 and col = width-1.
  - When no pixel was accepted, o_win_valid/o_eol/o_eof = 0; o_col/o_row hold their last value.
- o_busy = (state != IDLE), registered with the state.
- o_lb_width = latched width, stable for the whole frame.
- Gaps in i_valid stall all counters; there is no timeout.
- Reset mid-frame: immediate return to reset values; the next frame needs a new SOF.

Test Plan:
- W=8, H=5, KSIZE=3, 40 back-to-back pixels, SOF on the first:
  - o_lb_we high 40 cycles.
  - o_win_valid high 18 times; the first is 1 cycle after pixel index 18 with o_row=2, o_col=2.
  - o_eol 5 pulses; single o_eof after pixel 39 with o_row=4, o_col=7; o_busy low afterwards.
- Same frame with i_valid toggling 1-0-0-1 randomly:
  - Identical sequence of (o_row, o_col, o_win_valid), each 1 cycle after its accepted pixel.
  - No output strobes on idle cycles.
- SOF with width=2 (< KSIZE), then SOF with height=4000:
  - o_cfg_err pulses each time; o_lb_we stays 0; o_busy 0.
- Frame W=8 H=5; SOF again at pixel 20:
  - No o_eof for the first frame.
  - Counters restart at (0,0); state FILL; o_win_valid low until the new row 2, col 2.
- Change i_cfg_width from 8 to 16 mid-frame:
  - o_lb_width stays 8; eol spacing stays 8 until the next SOF latches 16.
- Assert rst_n low at pixel 25, then release:
  - All outputs 0; pixels without SOF dropped; a fresh SOF frame completes normally.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for a KSIZE-1 line-buffer chain feeding a KSIZE x KSIZE window stage.
// Tracks pixel coordinates and emits window strobes one cycle after each accepted pixel.
module line_buffer_ctrl #(
  parameter int KSIZE      = 3,
  parameter int MAX_WIDTH  = 2048,
  parameter int MAX_HEIGHT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_cfg_width,
  input  logic [15:0] i_cfg_height,
  input  logic        i_sof,
  input  logic        i_valid,
  output logic        o_lb_we,
  output logic [15:0] o_lb_width,
  output logic        o_win_valid,
  output logic [15:0] o_col,
  output logic [15:0] o_row,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_busy,
  output logic        o_cfg_err
);

  localparam logic [15:0] K    = 16'(KSIZE);
  localparam logic [15:0] KM1  = 16'(KSIZE - 1);
  localparam logic [15:0] MAXW = 16'(MAX_WIDTH);
  localparam logic [15:0] MAXH = 16'(MAX_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t      state;
  logic [15:0] col, row, width_q, height_q;
  logic        cfg_ok, sof_ok, sof_bad, accept;
  logic [15:0] pix_col, pix_row, w_eff, h_eff, row_next;
  logic        last_col, last_row;

  // An accepted SOF pixel is evaluated against the incoming geometry at (0,0).
  always_comb begin
    cfg_ok   = (i_cfg_width >= K) && (i_cfg_width <= MAXW) &&
               (i_cfg_height >= K) && (i_cfg_height <= MAXH);
    sof_ok   = i_valid & i_sof & cfg_ok;
    sof_bad  = i_valid & i_sof & ~cfg_ok;
    accept   = sof_ok | (i_valid & ~i_sof & (state != IDLE));
    pix_col  = sof_ok ? 16'd0 : col;
    pix_row  = sof_ok ? 16'd0 : row;
    w_eff    = sof_ok ? i_cfg_width  : width_q;
    h_eff    = sof_ok ? i_cfg_height : height_q;
    last_col = (pix_col == w_eff - 16'd1);
    last_row = (pix_row == h_eff - 16'd1);
    row_next = pix_row + 16'd1;
  end

  assign o_lb_we    = accept & rst_n;
  assign o_lb_width = width_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      width_q     <= '0;
      height_q    <= '0;
      o_win_valid <= 1'b0;
      o_col       <= '0;
      o_row       <= '0;
      o_eol       <= 1'b0;
      o_eof       <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_win_valid <= 1'b0;
      o_eol       <= 1'b0;
      o_eof       <= 1'b0;
      o_cfg_err   <= 1'b0;
      if (sof_bad) begin
        state     <= IDLE;
        o_busy    <= 1'b0;
        col       <= '0;
        row       <= '0;
        o_cfg_err <= 1'b1;
      end else if (accept) begin
        if (sof_ok) begin
          width_q  <= i_cfg_width;
          height_q <= i_cfg_height;
        end
        o_col       <= pix_col;
        o_row       <= pix_row;
        o_win_valid <= (pix_row >= KM1) && (pix_col >= KM1);
        o_eol       <= last_col;
        o_eof       <= last_col && last_row;
        if (last_col && last_row) begin
          state  <= IDLE;
          o_busy <= 1'b0;
          col    <= '0;
          row    <= '0;
        end else if (last_col) begin
          col    <= '0;
          row    <= row_next;
          state  <= (row_next >= KM1) ? RUN : FILL;
          o_busy <= 1'b1;
        end else begin
          col    <= pix_col + 16'd1;
          row    <= pix_row;
          state  <= (pix_row >= KM1) ? RUN : FILL;
          o_busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: the driver pushes expected per-cycle responses,
// a negedge monitor pops them and compares, and strobe tallies are checked per scenario.
module tb_line_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_width = '0, cfg_height = '0;
  logic        sof = 1'b0, valid = 1'b0;
  logic        lb_we, win_valid, eol, eof, busy, cfg_err;
  logic [15:0] lb_width, col, row;

  line_buffer_ctrl #(.KSIZE(3), .MAX_WIDTH(2048), .MAX_HEIGHT(2048)) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_width(cfg_width), .i_cfg_height(cfg_height),
    .i_sof(sof), .i_valid(valid), .o_lb_we(lb_we), .o_lb_width(lb_width),
    .o_win_valid(win_valid), .o_col(col), .o_row(row), .o_eol(eol), .o_eof(eof),
    .o_busy(busy), .o_cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] col, row, lbw;
    logic        win, eol, eof, busy, err;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  logic have_pend = 1'b0;

  int n_checks = 0, n_pass = 0;
  int we_cnt = 0, win_cnt = 0, eol_cnt = 0, eof_cnt = 0, err_cnt = 0;
  logic        first_win_seen = 1'b0;
  logic [15:0] first_win_row = '0, first_win_col = '0, eof_row = '0, eof_col = '0;

  // Reference model of the sequencer's externally visible behaviour.
  logic        m_active = 1'b0;
  logic [15:0] m_col = '0, m_row = '0, m_w = '0, m_h = '0, m_ocol = '0, m_orow = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic clearCounts();
    we_cnt = 0; win_cnt = 0; eol_cnt = 0; eof_cnt = 0; err_cnt = 0;
    first_win_seen = 1'b0;
  endtask

  task automatic modelReset();
    m_active = 1'b0; m_col = '0; m_row = '0; m_w = '0; m_h = '0; m_ocol = '0; m_orow = '0;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [15:0] w, input logic [15:0] h);
    exp_t e;
    logic legal, acc;
    @(posedge clk); #1;
    valid = v; sof = s; cfg_width = w; cfg_height = h;
    legal = (w >= 16'd3) && (w <= 16'd2048) && (h >= 16'd3) && (h <= 16'd2048);
    e.win = 1'b0; e.eol = 1'b0; e.eof = 1'b0; e.err = 1'b0;
    acc = 1'b0;
    if (v && s) begin
      if (legal) begin
        m_w = w; m_h = h; m_active = 1'b1; m_col = '0; m_row = '0; acc = 1'b1;
      end else begin
        e.err = 1'b1; m_active = 1'b0; m_col = '0; m_row = '0;
      end
    end else if (v && m_active) acc = 1'b1;
    if (acc) begin
      m_ocol = m_col; m_orow = m_row;
      e.win = (m_row >= 16'd2) && (m_col >= 16'd2);
      e.eol = (m_col == m_w - 16'd1);
      e.eof = e.eol && (m_row == m_h - 16'd1);
      if (e.eof) begin m_active = 1'b0; m_col = '0; m_row = '0; end
      else if (e.eol) begin m_col = '0; m_row = m_row + 16'd1; end
      else m_col = m_col + 16'd1;
    end
    e.we = acc; e.col = m_ocol; e.row = m_orow; e.lbw = m_w; e.busy = m_active;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, cfg_width, cfg_height);
  endtask

  task automatic sendPixels(input int n, input logic first_sof, input logic [15:0] w,
                            input logic [15:0] h, input int max_gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, first_sof && (i == 0), w, h);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic doReset(input int cycles);
    @(posedge clk); #1;
    valid = 1'b0; sof = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    modelReset();
    #1;
    checkOutput("rst_lb_we", lb_we, 0);
    checkOutput("rst_win_valid", win_valid, 0);
    checkOutput("rst_col", col, 0);
    checkOutput("rst_row", row, 0);
    checkOutput("rst_eol", eol, 0);
    checkOutput("rst_eof", eof, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_lb_width", lb_width, 0);
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: registered outputs of the previous record, then lb_we of the current one.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_pend = 1'b0;
    end else begin
      we_cnt  += int'(lb_we);
      win_cnt += int'(win_valid);
      eol_cnt += int'(eol);
      eof_cnt += int'(eof);
      err_cnt += int'(cfg_err);
      if (win_valid && !first_win_seen) begin
        first_win_seen = 1'b1; first_win_row = row; first_win_col = col;
      end
      if (eof) begin eof_row = row; eof_col = col; end
      if (have_pend) begin
        checkOutput("col", col, pend.col);
        checkOutput("row", row, pend.row);
        checkOutput("win_valid", win_valid, pend.win);
        checkOutput("eol", eol, pend.eol);
        checkOutput("eof", eof, pend.eof);
        checkOutput("busy", busy, pend.busy);
        checkOutput("cfg_err", cfg_err, pend.err);
        checkOutput("lb_width", lb_width, pend.lbw);
      end else begin
        checkOutput("idle_strobes", {win_valid, eol, eof}, 0);
      end
      if (exp_q.size() > 0) begin
        pend = exp_q.pop_front();
        have_pend = 1'b1;
        checkOutput("lb_we", lb_we, pend.we);
      end else begin
        have_pend = 1'b0;
      end
    end
  end

  initial begin
    doReset(3);

    $display("[TB] back-to-back 8x5 frame");
    clearCounts();
    sendPixels(40, 1'b1, 16'd8, 16'd5, 0);
    idle(3);
    checkOutput("f1_we_count", we_cnt, 40);
    checkOutput("f1_win_count", win_cnt, 18);
    checkOutput("f1_first_win_row", first_win_row, 2);
    checkOutput("f1_first_win_col", first_win_col, 2);
    checkOutput("f1_eol_count", eol_cnt, 5);
    checkOutput("f1_eof_count", eof_cnt, 1);
    checkOutput("f1_eof_row", eof_row, 4);
    checkOutput("f1_eof_col", eof_col, 7);
    checkOutput("f1_busy_after", busy, 0);

    $display("[TB] gapped 8x5 frame");
    clearCounts();
    sendPixels(40, 1'b1, 16'd8, 16'd5, 2);
    idle(3);
    checkOutput("f2_we_count", we_cnt, 40);
    checkOutput("f2_win_count", win_cnt, 18);
    checkOutput("f2_eol_count", eol_cnt, 5);
    checkOutput("f2_eof_count", eof_cnt, 1);

    $display("[TB] illegal geometry");
    clearCounts();
    applyStimulus(1'b1, 1'b1, 16'd2, 16'd5);
    idle(2);
    applyStimulus(1'b1, 1'b1, 16'd8, 16'd4000);
    sendPixels(3, 1'b0, 16'd8, 16'd5, 0);
    idle(2);
    checkOutput("cfg_err_count", err_cnt, 2);
    checkOutput("cfg_we_count", we_cnt, 0);
    checkOutput("cfg_busy", busy, 0);

    $display("[TB] restart at pixel 20");
    clearCounts();
    sendPixels(20, 1'b1, 16'd8, 16'd5, 0);
    sendPixels(40, 1'b1, 16'd8, 16'd5, 0);
    idle(3);
    checkOutput("rs_win_count", win_cnt, 20);
    checkOutput("rs_eol_count", eol_cnt, 7);
    checkOutput("rs_eof_count", eof_cnt, 1);

    $display("[TB] live width change mid-frame");
    clearCounts();
    sendPixels(10, 1'b1, 16'd8, 16'd5, 0);
    sendPixels(30, 1'b0, 16'd16, 16'd5, 0);
    idle(2);
    checkOutput("wc_eol_count", eol_cnt, 5);
    checkOutput("wc_eof_count", eof_cnt, 1);
    checkOutput("wc_lb_width", lb_width, 8);
    clearCounts();
    sendPixels(48, 1'b1, 16'd16, 16'd3, 0);
    idle(2);
    checkOutput("w16_eol_count", eol_cnt, 3);
    checkOutput("w16_win_count", win_cnt, 14);
    checkOutput("w16_lb_width", lb_width, 16);

    $display("[TB] reset mid-frame");
    sendPixels(25, 1'b1, 16'd8, 16'd5, 0);
    doReset(2);
    clearCounts();
    sendPixels(5, 1'b0, 16'd8, 16'd5, 0);
    idle(1);
    checkOutput("pr_we_count", we_cnt, 0);
    sendPixels(40, 1'b1, 16'd8, 16'd5, 0);
    idle(3);
    checkOutput("pr_we_total", we_cnt, 40);
    checkOutput("pr_win_count", win_cnt, 18);
    checkOutput("pr_eof_count", eof_cnt, 1);
    checkOutput("pr_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
